// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle ARM controller: FSM states,
// datapath mux encodings, ALU command decode and condition codes.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH
   } state_t;

   // ALUControl encodings
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // ResultSrc encodings
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Data-processing commands, Funct[4:1]
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   // ARM condition field values
   localparam logic [3:0] COND_EQ = 4'd0;
   localparam logic [3:0] COND_NE = 4'd1;
   localparam logic [3:0] COND_CS = 4'd2;
   localparam logic [3:0] COND_CC = 4'd3;
   localparam logic [3:0] COND_MI = 4'd4;
   localparam logic [3:0] COND_PL = 4'd5;
   localparam logic [3:0] COND_VS = 4'd6;
   localparam logic [3:0] COND_VC = 4'd7;
   localparam logic [3:0] COND_HI = 4'd8;
   localparam logic [3:0] COND_LS = 4'd9;
   localparam logic [3:0] COND_GE = 4'd10;
   localparam logic [3:0] COND_LT = 4'd11;
   localparam logic [3:0] COND_GT = 4'd12;
   localparam logic [3:0] COND_LE = 4'd13;
   localparam logic [3:0] COND_AL = 4'd14;

   function automatic logic cmd_legal(input logic [3:0] cmd);
      return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
             (cmd == CMD_CMP) || (cmd == CMD_ORR);
   endfunction

   // ADD/SUB/CMP update C and V; logical ops only touch N and Z.
   function automatic logic cmd_arith(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
   endfunction

   function automatic logic [2:0] alu_op(input logic [3:0] cmd);
      case (cmd)
         CMD_SUB, CMD_CMP: return ALU_SUB;
         CMD_AND:          return ALU_AND;
         CMD_ORR:          return ALU_ORR;
         default:          return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_condlogic.sv
// Flag register {N,Z,C,V} and conditional-execution evaluation.
// Cond=15 is treated as "never".
module mc_condlogic
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   output logic       cond_ex
);

   logic [3:0] flags;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags;

   // Load NZ and CV independently under their write enables.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags <= 4'b0000;
      end else begin
         if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
         if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
      end
   end

   // Evaluate the condition field against the stored flags.
   // NOTE: the default arm assigns cond_ex on every path, so no latch is inferred.
   always_comb begin
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = !z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = !c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = !n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = !v;
         COND_HI: cond_ex = c && !z;
         COND_LS: cond_ex = !c || z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = !z && (n == v);
         COND_LE: cond_ex = z || (n != v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: FSM sequencing fetch/decode/execute/memory/
// writeback with a MemReady handshake, squashing of non-executing
// instructions and an optional retired-instruction counter enabled by the
// CTRL_RETIRE_CNT_EN macro (Retired is tied to 0 when it is undefined).
module multicycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W         = 32,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:12]     Instr,
   input  logic [3:0]       ALUFlags,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             AdrSrc,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ImmSrc,
   output logic [1:0]       RegSrc,
   output logic [2:0]       ALUControl,
   output logic             Illegal,
   output logic [CNT_W-1:0] Retired
);

   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] cond;
   logic [3:0] cmd;
   logic       mem_ready;
   logic       cond_ex;
   logic       in_exec;
   logic       illegal_instr;
   logic [1:0] flag_w;
   logic [3:0] unused_rn;
   state_t     state;

   assign op        = Instr[27:26];
   assign funct     = Instr[25:20];
   assign rd        = Instr[15:12];
   assign cond      = Instr[31:28];
   assign cmd       = funct[4:1];
   assign unused_rn = Instr[19:16];

   assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

   assign illegal_instr = (op == 2'b11) || ((op == 2'b00) && !cmd_legal(cmd));

   // Flags are only written in the execute cycle, from that cycle's ALU result.
   assign in_exec = (state == S_EXECR) || (state == S_EXECI);
   assign flag_w  = in_exec ? {funct[0], funct[0] & cmd_arith(cmd)} : 2'b00;

   mc_condlogic u_condlogic (
      .clk       (clk),
      .reset     (reset),
      .cond      (cond),
      .alu_flags (ALUFlags),
      .flag_w    (flag_w),
      .cond_ex   (cond_ex)
   );

   // Main sequencer: one state per cycle, stalling in FETCH/MEMRD/MEMWR on memory.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  if (mem_ready) state <= S_DECODE;
            S_DECODE: begin
               if (!cond_ex || illegal_instr) begin
                  state <= S_FETCH;
               end else begin
                  case (op)
                     2'b00:   state <= funct[5] ? S_EXECI : S_EXECR;
                     2'b01:   state <= S_MEMADR;
                     2'b10:   state <= S_BRANCH;
                     default: state <= S_FETCH;
                  endcase
               end
            end
            S_MEMADR: state <= funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state <= S_MEMWB;
            S_MEMWR:  if (mem_ready) state <= S_FETCH;
            S_EXECR,
            S_EXECI:  state <= S_ALUWB;
            default:  state <= S_FETCH;
         endcase
      end
   end

   // Moore datapath controls per state; strobes are forced low while reset is held.
   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b1;
      ALUSrcB    = SRCB_FOUR;
      ResultSrc  = RES_ALURESULT;
      ALUControl = ALU_ADD;
      case (state)
         S_FETCH: begin
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b0;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            AdrSrc    = 1'b1;
            ResultSrc = RES_ALUOUT;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            if (rd == 4'd15) PCWrite = 1'b1;
            else             RegWrite = 1'b1;
         end
         S_MEMWR: begin
            AdrSrc    = 1'b1;
            ResultSrc = RES_ALUOUT;
            MemWrite  = 1'b1;
         end
         S_EXECR, S_EXECI: begin
            ALUSrcA    = 1'b0;
            ALUSrcB    = (state == S_EXECI) ? SRCB_IMM : SRCB_REG;
            ALUControl = alu_op(cmd);
         end
         S_ALUWB: begin
            ResultSrc = RES_ALUOUT;
            if (cmd != CMD_CMP) begin
               if (rd == 4'd15) PCWrite = 1'b1;
               else             RegWrite = 1'b1;
            end
         end
         S_BRANCH: begin
            ALUSrcA   = 1'b0;
            ALUSrcB   = SRCB_IMM;
            ResultSrc = RES_ALURESULT;
            PCWrite   = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
      end
   end

   assign Illegal = (state == S_DECODE) && cond_ex && illegal_instr && !reset;

   assign ImmSrc = op;
   assign RegSrc = {op == 2'b01, op == 2'b10};

`ifdef CTRL_RETIRE_CNT_EN
   logic retire;

   assign retire = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BRANCH) ||
                   ((state == S_MEMWR) && mem_ready);

   // Count instructions on the exit cycle of their final state; wraps naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       Retired <= '0;
      else if (retire) Retired <= Retired + CNT_W'(1);
   end
`else
   assign Retired = '0;
`endif

endmodule
